// File: rtl/detect_event_counter.sv
// Counts falling edges of the detector's det_n into a 4-digit BCD total with HEX and LED outputs.
// Define BLANK_LZ_EN to blank leading zeros on hex3..hex1.
module detect_event_counter #(
    parameter int LED_HOLD = 25_000_000,
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        det_n,
    input  logic        clr,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic        led,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
);

    localparam int TW = $clog2(LED_HOLD + 1);
    localparam logic [TW-1:0] HOLD = TW'(LED_HOLD);
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef BLANK_LZ_EN
    localparam logic [6:0] HEX_RST_HI = SEG_BLANK;
`else
    localparam logic [6:0] HEX_RST_HI = SEG_ZERO;
`endif

    logic          r_s1;
    logic          r_s2;
    logic          r_s2_d;
    logic          w_event;
    logic [15:0]   r_bcd;
    logic [15:0]   w_bcd_inc;
    logic          w_carry;
    logic          w_all9;
    logic          r_ovf;
    logic          r_led;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [3:0]    w_blank;
    logic [6:0]    r_hex0;
    logic [6:0]    r_hex1;
    logic [6:0]    r_hex2;
    logic [6:0]    r_hex3;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        unique case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign w_event = r_s2_d & ~r_s2;
    assign w_all9  = (r_bcd == 16'h9999);

    // Ripple carry across the four digits in a single cycle
    always_comb begin
        w_bcd_inc = r_bcd;
        w_carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_bcd[4*i +: 4] == 4'd9) begin
                    w_bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_timer_nxt = r_timer;
        if (clr) begin
            w_timer_nxt = '0;
        end else if (w_event) begin
            w_timer_nxt = HOLD;
        end else if (r_timer != '0) begin
            w_timer_nxt = r_timer - TW'(1);
        end
    end

    always_comb begin
        w_blank = 4'b0000;
`ifdef BLANK_LZ_EN
        w_blank[3] = (r_bcd[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (r_bcd[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (r_bcd[7:4] == 4'd0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_s2_d  <= 1'b1;
            r_bcd   <= 16'h0000;
            r_ovf   <= 1'b0;
            r_led   <= 1'b0;
            r_timer <= '0;
            r_hex0  <= SEG_ZERO;
            r_hex1  <= HEX_RST_HI;
            r_hex2  <= HEX_RST_HI;
            r_hex3  <= HEX_RST_HI;
        end else begin
            r_s1    <= det_n;
            r_s2    <= r_s1;
            r_s2_d  <= r_s2;
            r_timer <= w_timer_nxt;
            r_led   <= (w_timer_nxt != '0);
            if (clr) begin
                r_bcd <= 16'h0000;
                r_ovf <= 1'b0;
            end else if (w_event) begin
                if (w_all9) begin
                    r_ovf <= 1'b1;
                    r_bcd <= SATURATE ? 16'h9999 : 16'h0000;
                end else begin
                    r_bcd <= w_bcd_inc;
                end
            end
            r_hex0 <= seg7(r_bcd[3:0]);
            r_hex1 <= w_blank[1] ? SEG_BLANK : seg7(r_bcd[7:4]);
            r_hex2 <= w_blank[2] ? SEG_BLANK : seg7(r_bcd[11:8]);
            r_hex3 <= w_blank[3] ? SEG_BLANK : seg7(r_bcd[15:12]);
        end
    end

    assign bcd  = r_bcd;
    assign ovf  = r_ovf;
    assign led  = r_led;
    assign hex0 = r_hex0;
    assign hex1 = r_hex1;
    assign hex2 = r_hex2;
    assign hex3 = r_hex3;

endmodule

// File: tb/tb_detect_event_counter.sv
// Randomised and directed bench for detect_event_counter, saturating and wrapping builds.
module tb_detect_event_counter;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        det_n = 1'b1;
    logic        clr = 1'b0;
    logic        cmp_en = 1'b0;

    logic [15:0] bcd_s, bcd_w;
    logic        ovf_s, ovf_w, led_s, led_w;
    logic [6:0]  h0_s, h1_s, h2_s, h3_s;
    logic [6:0]  h0_w, h1_w, h2_w, h3_w;

    int n_checks = 0;
    int n_errs = 0;

    always #5 clk = ~clk;

    detect_event_counter #(.LED_HOLD(HOLD), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .det_n(det_n), .clr(clr),
        .bcd(bcd_s), .ovf(ovf_s), .led(led_s),
        .hex0(h0_s), .hex1(h1_s), .hex2(h2_s), .hex3(h3_s)
    );

    detect_event_counter #(.LED_HOLD(HOLD), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .det_n(det_n), .clr(clr),
        .bcd(bcd_w), .ovf(ovf_w), .led(led_w),
        .hex0(h0_w), .hex1(h1_w), .hex2(h2_w), .hex3(h3_w)
    );

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [6:0] seg(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(int c);
        return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [6:0] exp_hex(int c, int i);
        int p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
`ifdef BLANK_LZ_EN
        if (i > 0 && c < p) return 7'b1111111;
`endif
        return seg((c / p) % 10);
    endfunction

    // Model: sampled det_n history, integer counts, LED cycles remaining
    int  h1, h2, h3;
    int  m_cs, m_cw, m_hs, m_hw, m_led;
    bit  m_os, m_ow, ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= 1; h2 <= 1; h3 <= 1;
            m_cs <= 0; m_cw <= 0; m_hs <= 0; m_hw <= 0;
            m_os <= 0; m_ow <= 0; m_led <= 0;
        end else begin
            ev = (h2 == 0) && (h3 == 1);
            h1 <= int'(det_n); h2 <= h1; h3 <= h2;
            m_hs <= m_cs;
            m_hw <= m_cw;
            if (clr) begin
                m_cs <= 0; m_cw <= 0; m_os <= 0; m_ow <= 0; m_led <= 0;
            end else if (ev) begin
                if (m_cs == 9999) m_os <= 1;
                else m_cs <= m_cs + 1;
                if (m_cw == 9999) begin
                    m_ow <= 1;
                    m_cw <= 0;
                end else begin
                    m_cw <= m_cw + 1;
                end
                m_led <= HOLD;
            end else if (m_led > 0) begin
                m_led <= m_led - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("bcd_s", bcd_s, to_bcd(m_cs));
            chk("ovf_s", 16'(ovf_s), 16'(m_os));
            chk("led_s", 16'(led_s), 16'(m_led != 0));
            chk("hex_s", {h3_s[3:0], h2_s[3:0], h1_s[3:0], h0_s[3:0]},
                {exp_hex(m_hs, 3)[3:0], exp_hex(m_hs, 2)[3:0],
                 exp_hex(m_hs, 1)[3:0], exp_hex(m_hs, 0)[3:0]});
            chk("hexhi_s", {4'h0, h3_s[6:4], h2_s[6:4], h1_s[6:4], h0_s[6:4]},
                {4'h0, exp_hex(m_hs, 3)[6:4], exp_hex(m_hs, 2)[6:4],
                 exp_hex(m_hs, 1)[6:4], exp_hex(m_hs, 0)[6:4]});
            chk("bcd_w", bcd_w, to_bcd(m_cw));
            chk("ovf_w", 16'(ovf_w), 16'(m_ow));
            chk("led_w", 16'(led_w), 16'(m_led != 0));
            chk("hex0_w", 16'(h0_w), 16'(exp_hex(m_hw, 0)));
            chk("hex3_w", 16'(h3_w), 16'(exp_hex(m_hw, 3)));
        end
    end

    task automatic pulse();
        @(negedge clk) det_n = 1'b0;
        @(negedge clk) det_n = 1'b1;
    endtask

    task automatic do_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic led_window(bit second, output int cnt);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            det_n = (i == 0 || (second && i == 5)) ? 1'b0 : 1'b1;
            if (led_s) cnt++;
        end
    endtask

    int lc;

    initial begin
        #2 rst_n = 1'b0;
        idle(3);
        cmp_en = 1'b1;
        chk("rst_bcd", bcd_s, 16'h0000);
        chk("rst_ovf", 16'(ovf_s), 16'h0);
        chk("rst_led", 16'(led_s), 16'h0);
        chk("rst_hex0", 16'(h0_s), 16'h0040);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_bcd", bcd_s, 16'h0000);

        pulse();
        idle(1);
        chk("lat_bcd_k1", bcd_s, 16'h0000);
        idle(1);
        chk("single_bcd", bcd_s, 16'h0001);
        chk("single_led", 16'(led_s), 16'h1);
        idle(1);
        chk("single_hex0", 16'(h0_s), 16'(7'b1111001));

        do_clr();
        repeat (10) pulse();
        idle(4);
        chk("ten_bcd", bcd_s, 16'h0010);

        do_clr();
        @(negedge clk) det_n = 1'b0;
        idle(100);
        det_n = 1'b1;
        idle(4);
        chk("long_low", bcd_s, 16'h0001);
        pulse();
        idle(4);
        chk("long_low2", bcd_s, 16'h0002);

        do_clr();
        repeat (42) pulse();
        idle(4);
        chk("pre_clr42", bcd_s, 16'h0042);
        pulse();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        chk("clrpri_bcd", bcd_s, 16'h0000);
        chk("clrpri_ovf", 16'(ovf_s), 16'h0);
        chk("clrpri_led", 16'(led_s), 16'h0);
        idle(3);
        chk("clrpri_hold", bcd_s, 16'h0000);

        idle(12);
        led_window(1'b0, lc);
        chk("led_single", 16'(lc), 16'd8);
        idle(12);
        led_window(1'b1, lc);
        chk("led_reload", 16'(lc), 16'd13);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            det_n = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 60) == 0);
        end
        @(negedge clk) begin det_n = 1'b1; clr = 1'b0; end

        pulse();
        pulse();
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_bcd", bcd_s, 16'h0000);
        chk("async_led", 16'(led_s), 16'h0);
        chk("async_hex0", 16'(h0_s), 16'h0040);
        @(negedge clk) rst_n = 1'b1;

        do_clr();
        repeat (9998) pulse();
        idle(4);
        chk("pre_sat_s", bcd_s, 16'h9998);
        chk("pre_sat_w", bcd_w, 16'h9998);
        pulse();
        pulse();
        idle(4);
        chk("sat_bcd", bcd_s, 16'h9999);
        chk("sat_ovf", 16'(ovf_s), 16'h1);
        chk("wrap_bcd", bcd_w, 16'h0000);
        chk("wrap_ovf", 16'(ovf_w), 16'h1);
        pulse();
        idle(4);
        chk("ovf_sticky", 16'(ovf_w), 16'h1);
        do_clr();
        chk("ovf_clr", 16'(ovf_s), 16'h0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
